mux_req_arbiter: RTL and testbench

// - Shares one registered 8-bit output path between NUM_REQ requesters with valid/ready handshakes.
// - Fixed priority by default: lowest index wins. An aging override stops low-priority requesters from starving.
// - Sits in front of the priority-mux datapath and takes over its select generation.
// - Forwards the winning requester's data and its index to one downstream consumer.

---
 rtl/mux_req_arbiter.sv | 86 ++++++++
 tb/tb_mux_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_req_arbiter.sv
// Registered N-to-1 request arbiter: fixed priority with an aging override.
// Forwards the winning payload, its source index and an aged flag.
module mux_req_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int AGE_LIMIT = 6,
   parameter int AGE_W     = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(NUM_REQ)-1:0] out_src,
   output logic                       out_aged,
   input  logic                       out_ready
);

   localparam int SRC_W = $clog2(NUM_REQ);
   localparam logic [AGE_W-1:0] CNT_MAX = '1;
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t             state;
   logic [AGE_W-1:0]   cnt [NUM_REQ];
   logic [NUM_REQ-1:0] aged;
   logic [SRC_W-1:0]   win;
   logic               win_aged;
   logic               can_load;
   logic               grant;

   // Aged requesters outrank plain ones; lowest index wins within a class.
   always_comb begin
      aged = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         aged[i] = req_valid[i] & (cnt[i] >= AGE_LIM);
      end
      win_aged = |aged;
      win      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (win_aged ? aged[i] : req_valid[i]) begin
            win = SRC_W'(i);
         end
      end
   end

   assign can_load  = (state == EMPTY) | out_ready;
   assign grant     = can_load & (|req_valid) & ~rst;
   assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_aged  <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         if (grant) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= req_data[win*DATA_W +: DATA_W];
            out_src   <= win;
            out_aged  <= win_aged;
         end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
         end
         // Saturate rather than wrap so a starved requester stays aged.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] || !req_valid[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] != CNT_MAX) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_req_arbiter.sv
// Scoreboard bench for mux_req_arbiter: directed aging, backpressure,
// saturation and reset cases plus a random back-to-back stream.
module tb_mux_req_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic        out_ready = 1'b0;

   logic [3:0]  req_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic        out_aged;

   logic [3:0]  s_req_ready;
   logic        s_out_valid;
   logic [7:0]  s_out_data;
   logic [1:0]  s_out_src;
   logic        s_out_aged;

   always #5 clk = ~clk;

   mux_req_arbiter #(
      .NUM_REQ(4), .DATA_W(8), .AGE_LIMIT(6), .AGE_W(3)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data),
      .out_src(out_src), .out_aged(out_aged),
      .out_ready(out_ready)
   );

   mux_req_arbiter #(
      .NUM_REQ(4), .DATA_W(8), .AGE_LIMIT(7), .AGE_W(3)
   ) sat (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data),
      .req_ready(s_req_ready),
      .out_valid(s_out_valid), .out_data(s_out_data),
      .out_src(s_out_src), .out_aged(s_out_aged),
      .out_ready(out_ready)
   );

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] src;
      logic       aged;
   } word_t;

   word_t      exp_q[$];
   logic [3:0] exp_ready = '0;
   int         mcnt [4] = '{0, 0, 0, 0};
   bit         mfull = 1'b0;
   bit         g_hit;
   int         g_idx;
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic hpush(input logic [7:0] d, input int s, input bit a);
      word_t e;
      e.data = d;
      e.src  = 2'(s);
      e.aged = a;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs and advance the reference arbiter.
   task automatic step(input logic r, input logic [3:0] v,
                       input logic [31:0] d, input logic ordy,
                       input bit push);
      int w;
      bit old;
      @(posedge clk);
      #1;
      rst       = r;
      req_valid = v;
      req_data  = d;
      out_ready = ordy;
      g_hit     = 1'b0;
      g_idx     = 0;
      exp_ready = '0;
      if (r) begin
         for (int i = 0; i < 4; i++) mcnt[i] = 0;
         mfull = 1'b0;
         exp_q.delete();
      end else begin
         w   = -1;
         old = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (w < 0 && v[i] && mcnt[i] >= 6) begin
               w   = i;
               old = 1'b1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (w < 0 && v[i]) w = i;
         end
         if ((!mfull || ordy) && w >= 0) begin
            exp_ready[w] = 1'b1;
            g_hit = 1'b1;
            g_idx = w;
            mfull = 1'b1;
            if (push) hpush(d[w*8 +: 8], w, old);
         end else if (ordy) begin
            mfull = 1'b0;
         end
         for (int i = 0; i < 4; i++) begin
            if (exp_ready[i] || !v[i]) mcnt[i] = 0;
            else if (mcnt[i] < 7) mcnt[i]++;
         end
      end
   endtask

   // Monitor: grant check every cycle, pop on each accepted word.
   always @(negedge clk) begin
      word_t e;
      if (!rst) begin
         chk("req_ready", req_ready, exp_ready);
         if (out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_word: got %0h src %0d, required none",
                        out_data, out_src);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e.data || out_src !== e.src ||
                   out_aged !== e.aged) begin
                  fails++;
                  $display("FAIL word: got %0h/%0d/%0d, required %0h/%0d/%0d",
                           out_data, out_src, out_aged,
                           e.data, e.src, e.aged);
               end
            end
         end
      end
   end

   logic [31:0] dd;
   logic [3:0]  pv;
   logic [31:0] pd;
   int          got;
   int          cyc;
   int          src_l  [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
   bit          aged_l [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_out_aged", out_aged, 0);
      chk("rst_req_ready", req_ready, 0);

      for (int k = 0; k < 3; k++) begin
         step(0, 4'b0000, 32'h0, 1, 0);
         @(negedge clk);
         chk("idle_valid", out_valid, 0);
      end

      // Single request, one-cycle latency.
      step(0, 4'b0100, 32'h00A5_0000, 1, 0);
      hpush(8'hA5, 2, 0);
      @(negedge clk);
      chk("single_ready", req_ready, 4'b0100);
      step(0, 4'b0000, 32'h0, 1, 0);
      @(negedge clk);
      chk("single_valid", out_valid, 1);

      // All requesting: aging promotes 1, 2, 3 in turn.
      dd = 32'h4433_2211;
      for (int k = 0; k < 10; k++) begin
         step(0, 4'b1111, dd, 1, 0);
         hpush(dd[src_l[k]*8 +: 8], src_l[k], aged_l[k]);
      end
      step(0, 4'b0000, dd, 1, 0);
      step(0, 4'b0000, dd, 1, 0);
      @(negedge clk);
      chk("age_drained", out_valid, 0);

      // Backpressure while full.
      step(0, 4'b0001, 32'h0000_0011, 0, 0);
      hpush(8'h11, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(0, 4'b0011, 32'h0000_3322, 0, 0);
         @(negedge clk);
         chk("bp_data", out_data, 8'h11);
         chk("bp_ready", req_ready, 0);
         chk("bp_valid", out_valid, 1);
      end
      step(0, 4'b0011, 32'h0000_3322, 1, 0);
      hpush(8'h22, 0, 0);
      @(negedge clk);
      chk("bp_resume", req_ready, 4'b0001);
      step(0, 4'b0010, 32'h0000_3300, 1, 0);
      hpush(8'h33, 1, 1);
      @(negedge clk);
      chk("bp_aged_grant", req_ready, 4'b0010);
      step(0, 4'b0000, 32'h0, 1, 0);
      step(0, 4'b0000, 32'h0, 1, 0);
      @(negedge clk);
      chk("bp_drained", out_valid, 0);

      // Counter saturation with requester 3 starved.
      step(1, 4'b0000, 32'h0, 0, 0);
      step(0, 4'b1001, dd, 0, 0);
      hpush(8'h11, 0, 0);
      for (int k = 0; k < 20; k++) step(0, 4'b1000, dd, 0, 0);
      step(0, 4'b1001, 32'h4433_2255, 1, 0);
      hpush(8'h44, 3, 1);
      @(negedge clk);
      chk("sat_ready", s_req_ready, 4'b1000);
      step(0, 4'b0001, 32'h4433_2255, 1, 0);
      hpush(8'h55, 0, 0);
      @(negedge clk);
      chk("sat_valid", s_out_valid, 1);
      chk("sat_data", s_out_data, 8'h44);
      chk("sat_src", s_out_src, 3);
      chk("sat_aged", s_out_aged, 1);
      step(0, 4'b0000, 32'h0, 1, 0);

      // Reset while full discards the word and clears aging.
      step(0, 4'b0010, 32'h0000_2200, 0, 0);
      for (int k = 0; k < 7; k++) step(0, 4'b0100, 32'h0033_2200, 0, 0);
      step(1, 4'b0110, 32'h0033_2200, 0, 0);
      @(negedge clk);
      chk("rst_full_ready", req_ready, 0);
      step(0, 4'b0110, 32'h0033_2200, 1, 0);
      hpush(8'h22, 1, 0);
      @(negedge clk);
      chk("rst_full_valid", out_valid, 0);
      chk("rst_full_grant", req_ready, 4'b0010);
      step(0, 4'b0100, 32'h0033_2200, 1, 0);
      hpush(8'h33, 2, 0);
      step(0, 4'b0000, 32'h0, 1, 0);
      step(0, 4'b0000, 32'h0, 1, 0);

      // Random back-to-back stream through the reference model.
      pv  = 4'b1111;
      pd  = $urandom;
      got = 0;
      cyc = 0;
      while (got < 1000 && cyc < 5000) begin
         step(0, pv, pd, 1, 1);
         @(negedge clk);
         if (cyc > 0) chk("no_bubble", out_valid, 1);
         cyc++;
         if (g_hit) begin
            got++;
            pd[g_idx*8 +: 8] = 8'($urandom);
            pv[g_idx] = 1'($urandom_range(0, 1));
         end
         for (int i = 0; i < 4; i++) begin
            if (!pv[i]) begin
               pd[i*8 +: 8] = 8'($urandom);
               pv[i] = 1'($urandom_range(0, 1));
            end
         end
         if (pv == 4'b0000) pv[$urandom_range(0, 3)] = 1'b1;
      end
      chk("stream_count", got, 1000);
      step(0, 4'b0000, 32'h0, 1, 0);
      step(0, 4'b0000, 32'h0, 1, 0);
      @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
